io_event_regs: RTL
==================

Name: io_event_regs

Overview:
- Input-conditioning stage between raw board inputs (switches, buttons) and the AXI register read mux.
- Per input bit:
  - two-flop synchronisation;
  - counter-based debounce;
  - sticky rise/fall event capture;
  - maskable interrupt.
- Exposes four 32-bit registers through the same rreg/wreg/rdata/wdata/rd/wr strobe interface produced by axi_registers, so it drops in as a register bank.

Parameters:
WIDTH, 8, number of raw input bits (1..16); bits [3:0] = sw, [7:4] = btn in top-level use
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the stable level before it is accepted (>=1)

Ports:
clk  input  1  sole clock (axiclk domain)
reset  input  1  asynchronous, active-high reset
i_raw  input  WIDTH  asynchronous raw inputs
i_rreg  input  2  read register index
i_wreg  input  2  write register index
i_wdata  input  32  write data
i_rd  input  1  read strobe (informational; reads have no side effects)
i_wr  input  1  write strobe, one cycle per write
o_rdata  output  32  combinational read data for i_rreg
o_state  output  WIDTH  debounced stable levels
o_irq  output  1  level interrupt, registered

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous, active-high. While reset is asserted, all flops clear: sync stages, stable, counters, rise, fall, mask and o_irq are 0.
- Synchroniser: sync1 <= i_raw; sync2 <= sync1.
- Debounce counter, per bit, width $clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: raw change set up before edge N and held causes stable (o_state) to change after edge N+1+DEBOUNCE_CYCLES. Any reversion before then restarts the count.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
- Events:
  - rise[i] is set in the cycle stable[i] goes 0->1.
  - fall[i] is set in the cycle stable[i] goes 1->0.
  - Both are sticky until cleared.
- Register map (o_rdata zero-extended above the used bits):
  - 0 STATE: {0, stable}. Read-only; writes ignored.
  - 1 RISE: {0, rise}. Write-1-to-clear via i_wdata[WIDTH-1:0].
  - 2 FALL: {0, fall}. Write-1-to-clear.
  - 3 MASK: {0, fall_en[WIDTH-1:0] at [WIDTH+15:16], rise_en[WIDTH-1:0] at [WIDTH-1:0]}. Read/write; unused bits read 0.
- Read mux: combinational from i_rreg, zero latency, no read side effects.
- Write timing: writes take effect on the edge where i_wr=1.
- Simultaneous set and W1C on the same bit in the same cycle: the set wins (bit remains 1).
- Interrupt: o_irq <= |(rise & rise_en) | |(fall & fall_en). One cycle behind the event/mask state.
- Inputs high at reset: after reset release, stable rises through normal debounce and sets rise events. This is intentional.
- Reset mid-debounce discards the count. Reset mid-write discards the write.

Decomposition:
- Package io_event_pkg:
  - register index localparams REG_STATE=0, REG_RISE=1, REG_FALL=2, REG_MASK=3;
  - MASK field offset FALL_EN_LSB=16.
- Sub-module io_debounce_bit, generated WIDTH times:
  - contains the sync flops, counter and stable flop;
  - outputs stable, rise_pulse, fall_pulse.
- Event/mask registers, read mux and irq logic live in io_event_regs.

Test Plan:
(WIDTH=8, DEBOUNCE_CYCLES=4)
1. Reset with i_raw=0, then i_raw[0]=1 held from edge N -> o_state[0]=1 after edge N+5 (not N+4); RISE reads 0x01; o_irq stays 0 (mask 0).
2. Glitch: i_raw[5] high for 3 cycles, then low -> o_state unchanged, RISE/FALL remain 0. Repeat with a 4-cycle pulse -> o_state[5] pulses; RISE=0x20 and FALL=0x20.
3. Write MASK=0x0000_0001, then drive rise on bit 0 -> o_irq=1 one cycle after RISE[0] sets. Write RISE=0x01 -> RISE=0, o_irq=0 the following cycle.
4. W1C of RISE bit 2 on the same edge that stable[2] rises -> RISE[2] reads 1 afterwards.
5. Write STATE=0xFFFF_FFFF -> no change. Write MASK=0xFFFF_FFFF -> reads 0x00FF_00FF. Unselected register contents unaffected by any write.
6. Hold i_raw=0xFF through reset -> after release, o_state=0xFF after 6 edges and RISE=0xFF. Assert reset mid-count on a second transition -> all outputs 0 immediately (async), with no event after release unless the input is still differing.

Source files
------------

// File: rtl/io_event_pkg.sv
// io_event_pkg: shared constants for the io_event_regs register bank.
//   REG_*        register indices as seen on rreg/wreg
//   FALL_EN_LSB  bit offset of the fall-enable field inside the MASK register
//   REG_W        register data width
package io_event_pkg;

  localparam int REG_W = 32;

  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_RISE  = 2'd1;
  localparam logic [1:0] REG_FALL  = 2'd2;
  localparam logic [1:0] REG_MASK  = 2'd3;

  localparam int FALL_EN_LSB = 16;

endpackage

// File: rtl/io_debounce_bit.sv
// io_debounce_bit: conditions one raw board input.
// Two-flop synchroniser followed by a counter debounce: the synchronised
// level must differ from the stable level for DEBOUNCE_CYCLES consecutive
// cycles before it is accepted. Any reversion restarts the count.
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   raw         asynchronous raw input
//   stable      debounced level
//   rise_pulse  high in the cycle whose closing edge takes stable 0->1
//   fall_pulse  high in the cycle whose closing edge takes stable 1->0
module io_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The pulses are the "about to change" condition, so the event register in
  // the parent sets on the very edge that stable changes.
  assign accept     = (sync2 != stable) && (cnt == CNT_LAST);
  assign rise_pulse = accept & ~stable;
  assign fall_pulse = accept &  stable;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // with = the synchroniser would collapse into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_event_regs.sv
// io_event_regs: input-conditioning register bank for switches/buttons.
// Each raw bit is synchronised and debounced; debounced edges set sticky
// RISE/FALL bits, which are maskable into a registered level interrupt.
// Registers (32-bit, zero-extended):
//   0 STATE  debounced levels, read-only
//   1 RISE   sticky rise events, write-1-to-clear
//   2 FALL   sticky fall events, write-1-to-clear
//   3 MASK   rise_en at [WIDTH-1:0], fall_en at [WIDTH+15:16], read/write
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_raw            asynchronous raw inputs
//   i_rreg, o_rdata  read index and combinational read data
//   i_wreg, i_wdata  write index and data, committed on edges with i_wr=1
//   i_rd             read strobe (reads have no side effects)
//   o_state          debounced levels
//   o_irq            registered level interrupt
module io_event_regs
  import io_event_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  input  logic [1:0]       i_rreg,
  input  logic [1:0]       i_wreg,
  input  logic [REG_W-1:0] i_wdata,
  input  logic             i_rd,
  input  logic             i_wr,
  output logic [REG_W-1:0] o_rdata,
  output logic [WIDTH-1:0] o_state,
  output logic             o_irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic             wr_mask;

  // Reads are side-effect free and only part of i_wdata is meaningful.
  logic unused_ok;
  assign unused_ok = ^{i_rd, i_wdata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    io_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .raw        (i_raw[i]),
      .stable     (stable[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign o_state  = stable;
  assign rise_clr = (i_wr && i_wreg == REG_RISE) ? i_wdata[WIDTH-1:0] : '0;
  assign fall_clr = (i_wr && i_wreg == REG_FALL) ? i_wdata[WIDTH-1:0] : '0;
  assign wr_mask  = i_wr && (i_wreg == REG_MASK);

  // The set term is OR-ed after the clear, so a new event wins over a
  // simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise    <= '0;
      fall    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      o_irq   <= 1'b0;
    end else begin
      rise  <= (rise & ~rise_clr) | rise_pulse;
      fall  <= (fall & ~fall_clr) | fall_pulse;
      o_irq <= (|(rise & rise_en)) | (|(fall & fall_en));
      if (wr_mask) begin
        rise_en <= i_wdata[WIDTH-1:0];
        fall_en <= i_wdata[FALL_EN_LSB +: WIDTH];
      end
    end
  end

  // NOTE: o_rdata gets its zero default before the case so every path
  // assigns every bit and no latch is inferred.
  always_comb begin
    o_rdata = '0;
    case (i_rreg)
      REG_STATE: o_rdata[WIDTH-1:0] = stable;
      REG_RISE:  o_rdata[WIDTH-1:0] = rise;
      REG_FALL:  o_rdata[WIDTH-1:0] = fall;
      REG_MASK: begin
        o_rdata[WIDTH-1:0]             = rise_en;
        o_rdata[FALL_EN_LSB +: WIDTH]  = fall_en;
      end
      default: ;
    endcase
  end

endmodule
